// File: rtl/clock_controller_pkg.sv
// clock_controller_pkg
//   Shared types for the programmable CPU clock-enable generator.
//   clk_mode_t encodes the 2-bit mode input. The reserved encoding is
//   listed so that a cast from the raw port value is always a named member.
//   The controller treats it exactly like MODE_HALT.
package clock_controller_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } clk_mode_t;

endpackage

// File: rtl/step_sync.sv
// step_sync
//   Turns a raw, asynchronous single-step button level into a one-cycle
//   pulse in the clk_in domain. It uses a 2-flop synchroniser followed by a
//   rising-edge detector, so one press gives exactly one pulse no matter how
//   long the button is held.
//   Ports:
//     clk_in     in  system clock
//     reset      in  asynchronous, active-high reset
//     step_raw   in  raw button level (asynchronous)
//     step_pulse out one-cycle pulse, two cycles after the raw rising edge
module step_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic step_raw,
  output logic step_pulse
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], step_raw};
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign step_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clock_controller.sv
// clock_controller
//   Programmable CPU clock-enable generator. It produces a one-cycle tick
//   every 'divisor' clk_in cycles in RUN mode, one tick per request in STEP
//   mode, and no ticks in HALT or reserved mode. It also produces clk_out,
//   which toggles on every tick, and a sticky halted flag that is set by the
//   CPU's HLT instruction.
//   Build option: when CLOCK_CONTROLLER_STEP_SYNC_EN is defined, step_req is
//   treated as a raw button level and passes through step_sync. Otherwise
//   step_req is a synchronous pulse that is used directly.
//   Ports:
//     clk_in     in  system clock
//     reset      in  asynchronous, active-high reset
//     mode       in  00 HALT, 01 RUN, 10 STEP, 11 reserved (HALT)
//     step_req   in  single-step request
//     div_load   in  one-cycle pulse that loads div_value (0 is taken as 1)
//     div_value  in  new divisor in clk_in cycles per tick
//     halt_in    in  CPU HLT, sets the sticky halt
//     tick       out one-cycle CPU enable
//     clk_out    out 50 % duty heartbeat, toggles on each tick
//     running    out registered (mode == RUN && !halted)
//     halted     out sticky halt flag, cleared only by reset
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter int          CNT_WIDTH   = 26,
  parameter int unsigned DEFAULT_DIV = 25_000_000
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 step_req,
  input  logic                 div_load,
  input  logic [CNT_WIDTH-1:0] div_value,
  input  logic                 halt_in,
  output logic                 tick,
  output logic                 clk_out,
  output logic                 running,
  output logic                 halted
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic step_pulse;

`ifdef CLOCK_CONTROLLER_STEP_SYNC_EN
  step_sync u_step_sync (
    .clk_in     (clk_in),
    .reset      (reset),
    .step_raw   (step_req),
    .step_pulse (step_pulse)
  );
`else
  assign step_pulse = step_req;
`endif

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic                 tick_q, tick_d;
  logic                 clk_out_q, clk_out_d;
  logic                 running_q, running_d;
  logic                 halted_q, halted_d;
  logic                 pend_q, pend_d;
  clk_mode_t            mode_e;
  logic                 terminal;

  always_comb begin
    // NOTE: every signal gets a default before the case below, so no path leaves it unassigned (no latch).
    mode_e    = clk_mode_t'(mode);
    terminal  = (cnt_q == div_q - ONE);
    cnt_d     = cnt_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    pend_d    = pend_q;
    halted_d  = halted_q | halt_in;
    running_d = (mode_e == MODE_RUN) && !halted_q;

    // The counter is held at 0 outside RUN, and pending is cleared outside
    // STEP. Together these make any mode change restart the period and
    // cancel a pending step.
    case (mode_e)
      MODE_RUN: begin
        pend_d = 1'b0;
        if (!halted_q) begin
          if (terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      MODE_STEP: begin
        cnt_d = '0;
        // Pending lasts for the single cycle in which its tick is emitted.
        // A request that arrives while it is set is dropped.
        if (pend_q) begin
          pend_d = 1'b0;
        end else if (step_pulse && !halted_q) begin
          pend_d = 1'b1;
          tick_d = 1'b1;
        end
      end
      default: begin
        cnt_d  = '0;
        pend_d = 1'b0;
      end
    endcase

    // A divisor load restarts the period. It also suppresses a terminal
    // count that falls in the same cycle.
    if (div_load) begin
      div_d = (div_value == '0) ? ONE : div_value;
      cnt_d = '0;
      if (mode_e == MODE_RUN) tick_d = 1'b0;
    end

    if (tick_d) clk_out_d = ~clk_out_q;
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= CNT_WIDTH'(DEFAULT_DIV);
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      pend_q    <= pend_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign running = running_q;
  assign halted  = halted_q;

endmodule
